ros2_app_data_arbiter: RTL and testbench
========================================

// Module: ros2_app_data_arbiter
// PURPOSE
//   Arbitrates exclusive ownership of the shared ROS2 app_data buffer between the
//   ros2 HLS core (IP) and the host CPU. Sits inside ros2_ether, between
//   app_data_req/rel_ap_vld and app_data_grant. Adds round-robin fairness on ties,
//   a guard gap between owners, and an optional hold-timeout watchdog.
// PARAMETERS
//   GUARD_CYCLES    2     idle cycles forced after every release/revoke (>=1)
//   TIMEOUT_CYCLES  4096  max grant hold before forced revoke (ARB_TIMEOUT_EN only)
//   CNT_WIDTH       16    width of grant/revoke statistics counters
// PORTS
//   clk_int         in   1          system clock
//   rst_int         in   1          asynchronous reset, active-high
//   ip_req          in   1          IP request pulse (ap_vld style, 1 cycle)
//   ip_rel          in   1          IP release pulse
//   cpu_req         in   1          CPU request pulse
//   cpu_rel         in   1          CPU release pulse
//   ip_grant        out  1          IP owns app_data
//   cpu_grant       out  1          CPU owns app_data
//   app_data_grant  out  8          {7'b0, ip_grant}, drives ros2 core directly
//   busy            out  1          state != IDLE
//   grant_count     out  CNT_WIDTH  total grants issued, saturating
//   revoke_count    out  CNT_WIDTH  total timeout revokes, saturating
//   timeout_pulse   out  1          1-cycle pulse on forced revoke
// BEHAVIOUR
//   - Reset: all outputs 0, state IDLE, pend_ip=pend_cpu=0, last_owner=CPU, counters 0.
//   - Pending latches: a *_req pulse sets pend_x unless x is current owner (ignored).
//     pend_x clears in the cycle grant is issued to x. Repeated reqs do not queue.
//   - States: IDLE, GNT_IP, GNT_CPU, GUARD.
//     IDLE: eff_x = pend_x | x_req. Only one eff -> grant it. Both -> grant the
//       requester != last_owner (IP wins first tie after reset). Grant is registered:
//       req at cycle n in IDLE -> grant high at n+1. last_owner updated on grant.
//     GNT_x: x_rel -> grant low next cycle, enter GUARD. rel from non-owner ignored.
//     GUARD: counts GUARD_CYCLES, then IDLE; reqs during GUARD are latched only.
//   - Exactly one of ip_grant/cpu_grant high at most; never both (assertion).
//   - Simultaneous: owner rel + other req same cycle -> release, other pended,
//     granted GUARD_CYCLES+1 cycles after grant drop. Owner rel+req same cycle ->
//     release then re-pend; round-robin hands next grant to other if it is pending.
//   - grant_count +1 per grant, holds at all-ones. revoke_count likewise per revoke.
//   - Reset mid-grant: grant drops asynchronously; pendings lost; requester must re-req.
// CONFIGURATION
//   ARB_TIMEOUT_EN defined: hold counter clears on entry to GNT_x, increments each
//     owned cycle; on reaching TIMEOUT_CYCLES-1 without rel, grant drops next cycle,
//     timeout_pulse=1 for that cycle, revoke_count+1, enter GUARD. A rel arriving in
//     the same cycle as expiry is a normal release (no pulse, no revoke count).
//   ARB_TIMEOUT_EN undefined: no watchdog; grant held until rel; timeout_pulse and
//     revoke_count tied 0; TIMEOUT_CYCLES unused.
// TESTING
//   1 ip_req @c10 -> ip_grant=1,app_data_grant=8'h01 @c11; ip_rel @c20 -> 0 @c21,
//     busy=0 @c23 (GUARD=2); grant_count=1.
//   2 ip_req & cpu_req same cycle after reset -> ip_grant first; ip_rel -> cpu_grant
//     high 3 cycles after ip_grant drop; repeat tie -> cpu then ip alternates.
//   3 cpu owns, ip_req @c5, cpu_rel @c5 -> cpu_grant low @c6, ip_grant high @c9.
//   4 ip_rel/cpu_rel while IDLE or from non-owner, ip_req while IP owns -> no state
//     change, grant_count unchanged.
//   5 ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16: cpu_req, no rel -> cpu_grant low 16 cycles
//     after rise, timeout_pulse 1 cycle, revoke_count=1; without macro grant holds 1000.
//   6 rst_int asserted mid GNT_IP -> ip_grant 0 immediately, counters 0; force
//     grant_count to 16'hFFFF then grant -> stays 16'hFFFF.

Source files
------------

// File: rtl/ros2_app_data_arbiter.sv
// ros2_app_data_arbiter: exclusive ownership arbiter for the shared ROS2
// app_data buffer, shared between the ros2 HLS core (IP) and the host CPU.
//
// Ports:
//   clk_int, rst_int         clock, asynchronous active-high reset
//   ip_req / ip_rel          IP request / release pulses (1 cycle)
//   cpu_req / cpu_rel        CPU request / release pulses (1 cycle)
//   ip_grant / cpu_grant     current owner (never both high)
//   app_data_grant           {7'b0, ip_grant}, fed straight to the ros2 core
//   busy                     arbiter not idle
//   grant_count              saturating count of grants issued
//   revoke_count             saturating count of watchdog revokes
//   timeout_pulse            1-cycle pulse on a watchdog revoke
//
// Optional feature: define ARB_TIMEOUT_EN to enable the hold-timeout
// watchdog. Without it, revoke_count and timeout_pulse are tied to 0.
module ros2_app_data_arbiter #(
    parameter int GUARD_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk_int,
    input  logic                 rst_int,
    input  logic                 ip_req,
    input  logic                 ip_rel,
    input  logic                 cpu_req,
    input  logic                 cpu_rel,
    output logic                 ip_grant,
    output logic                 cpu_grant,
    output logic [7:0]           app_data_grant,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] grant_count,
    output logic [CNT_WIDTH-1:0] revoke_count,
    output logic                 timeout_pulse
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GNT_IP,
        S_GNT_CPU,
        S_GUARD
    } state_t;

    localparam int GW = $clog2(GUARD_CYCLES) + 1;

    state_t               state_q, state_d;
    logic [GW-1:0]        guard_cnt_q, guard_cnt_d;
    logic                 pend_ip_q, pend_ip_d;
    logic                 pend_cpu_q, pend_cpu_d;
    // 1 when IP held the last grant; reset value 0 means CPU was last.
    logic                 last_ip_q, last_ip_d;
    logic [CNT_WIDTH-1:0] grant_count_q, grant_count_d;
    logic                 ip_grant_q, cpu_grant_q, busy_q;

    logic ip_own, cpu_own;
    logic eff_ip, eff_cpu;
    logic gnt_ip, gnt_cpu;
    logic expire;

`ifdef ARB_TIMEOUT_EN
    localparam int HW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [HW-1:0]        hold_q, hold_d;
    logic [CNT_WIDTH-1:0] revoke_count_q, revoke_count_d;
    logic                 timeout_pulse_q, timeout_pulse_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        ip_own  = (state_q == S_GNT_IP);
        cpu_own = (state_q == S_GNT_CPU);
        eff_ip  = pend_ip_q | ip_req;
        eff_cpu = pend_cpu_q | cpu_req;
        // On a tie the requester that did not own last time wins.
        gnt_ip  = (state_q == S_IDLE) && eff_ip
                  && (!eff_cpu || !last_ip_q);
        gnt_cpu = (state_q == S_IDLE) && eff_cpu && !gnt_ip;

`ifdef ARB_TIMEOUT_EN
        // A release in the expiry cycle wins: it is a normal release.
        expire = ((ip_own && !ip_rel) || (cpu_own && !cpu_rel))
                 && (hold_q == HW'(TIMEOUT_CYCLES - 1));
`else
        expire = 1'b0;
`endif

        state_d     = state_q;
        guard_cnt_d = guard_cnt_q;
        last_ip_d   = last_ip_q;

        unique case (state_q)
            S_IDLE: begin
                if (gnt_ip) begin
                    state_d   = S_GNT_IP;
                    last_ip_d = 1'b1;
                end else if (gnt_cpu) begin
                    state_d   = S_GNT_CPU;
                    last_ip_d = 1'b0;
                end
            end
            S_GNT_IP: begin
                if (ip_rel || expire) begin
                    state_d     = S_GUARD;
                    guard_cnt_d = '0;
                end
            end
            S_GNT_CPU: begin
                if (cpu_rel || expire) begin
                    state_d     = S_GUARD;
                    guard_cnt_d = '0;
                end
            end
            S_GUARD: begin
                if (guard_cnt_q == GW'(GUARD_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    guard_cnt_d = guard_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A request from the current owner is dropped unless it releases
        // in the same cycle, in which case it re-pends.
        pend_ip_d  = (pend_ip_q | (ip_req & ~(ip_own & ~ip_rel)))
                     & ~gnt_ip;
        pend_cpu_d = (pend_cpu_q | (cpu_req & ~(cpu_own & ~cpu_rel)))
                     & ~gnt_cpu;

        grant_count_d = grant_count_q;
        if ((gnt_ip || gnt_cpu) && !(&grant_count_q)) begin
            grant_count_d = grant_count_q + 1'b1;
        end

`ifdef ARB_TIMEOUT_EN
        hold_d = hold_q + 1'b1;
        if (gnt_ip || gnt_cpu) begin
            hold_d = '0;
        end
        revoke_count_d = revoke_count_q;
        if (expire && !(&revoke_count_q)) begin
            revoke_count_d = revoke_count_q + 1'b1;
        end
        timeout_pulse_d = expire;
`endif
    end

    always_ff @(posedge clk_int or posedge rst_int) begin
        if (rst_int) begin
            state_q       <= S_IDLE;
            guard_cnt_q   <= '0;
            pend_ip_q     <= 1'b0;
            pend_cpu_q    <= 1'b0;
            last_ip_q     <= 1'b0;
            grant_count_q <= '0;
            ip_grant_q    <= 1'b0;
            cpu_grant_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            guard_cnt_q   <= guard_cnt_d;
            pend_ip_q     <= pend_ip_d;
            pend_cpu_q    <= pend_cpu_d;
            last_ip_q     <= last_ip_d;
            grant_count_q <= grant_count_d;
            ip_grant_q    <= (state_d == S_GNT_IP);
            cpu_grant_q   <= (state_d == S_GNT_CPU);
            busy_q        <= (state_d != S_IDLE);
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk_int or posedge rst_int) begin
        if (rst_int) begin
            hold_q          <= '0;
            revoke_count_q  <= '0;
            timeout_pulse_q <= 1'b0;
        end else begin
            hold_q          <= hold_d;
            revoke_count_q  <= revoke_count_d;
            timeout_pulse_q <= timeout_pulse_d;
        end
    end

    assign revoke_count  = revoke_count_q;
    assign timeout_pulse = timeout_pulse_q;
`else
    assign revoke_count  = '0;
    assign timeout_pulse = 1'b0;
`endif

    assign ip_grant       = ip_grant_q;
    assign cpu_grant      = cpu_grant_q;
    assign app_data_grant = {7'b0, ip_grant_q};
    assign busy           = busy_q;
    assign grant_count    = grant_count_q;

    grant_exclusive_a: assert property (
        @(posedge clk_int) disable iff (rst_int)
        !(ip_grant_q && cpu_grant_q)
    );

endmodule

// File: tb/tb_ros2_app_data_arbiter.sv
// tb_ros2_app_data_arbiter: directed and randomized bench for
// ros2_app_data_arbiter, checked against an owner/pending/guard model.
module tb_ros2_app_data_arbiter;

    localparam int G    = 2;
    localparam int TO   = 16;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk_int = 1'b0;
    logic          rst_int = 1'b0;
    logic          ip_req = 1'b0, ip_rel = 1'b0;
    logic          cpu_req = 1'b0, cpu_rel = 1'b0;
    logic          ip_grant, cpu_grant, busy, timeout_pulse;
    logic [7:0]    app_data_grant;
    logic [CW-1:0] grant_count, revoke_count;

    int n_tests = 0;
    int n_fail  = 0;

    ros2_app_data_arbiter #(
        .GUARD_CYCLES  (G),
        .TIMEOUT_CYCLES(TO),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk_int       (clk_int),
        .rst_int       (rst_int),
        .ip_req        (ip_req),
        .ip_rel        (ip_rel),
        .cpu_req       (cpu_req),
        .cpu_rel       (cpu_rel),
        .ip_grant      (ip_grant),
        .cpu_grant     (cpu_grant),
        .app_data_grant(app_data_grant),
        .busy          (busy),
        .grant_count   (grant_count),
        .revoke_count  (revoke_count),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk_int = ~clk_int;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     nm, got, exp, $time);
        end
    endtask

    // Model: owner 0=none 1=IP 2=CPU, guard_left>0 means guard gap.
    int m_owner = 0, m_guard = 0, m_held = 0;
    int m_gc = 0, m_rc = 0;
    bit m_pip = 0, m_pcpu = 0, m_last_ip = 0, m_tp = 0;
    bit m_eip, m_ecpu, m_expire;

    always @(posedge clk_int or posedge rst_int) begin
        if (rst_int) begin
            m_owner = 0; m_guard = 0; m_held = 0;
            m_gc = 0; m_rc = 0;
            m_pip = 0; m_pcpu = 0; m_last_ip = 0; m_tp = 0;
        end else begin
            m_tp = 0;
            m_expire = 0;
`ifdef ARB_TIMEOUT_EN
            m_expire = (m_held == TO - 1);
`endif
            if (m_guard > 0) begin
                m_pip  |= ip_req;
                m_pcpu |= cpu_req;
                m_guard--;
            end else if (m_owner == 0) begin
                m_eip  = m_pip | ip_req;
                m_ecpu = m_pcpu | cpu_req;
                m_pip  = m_eip;
                m_pcpu = m_ecpu;
                if (m_eip && (!m_ecpu || !m_last_ip)) begin
                    m_owner = 1; m_pip = 0; m_last_ip = 1;
                    m_held = 0; m_gc = (m_gc < CMAX) ? m_gc + 1 : CMAX;
                end else if (m_ecpu) begin
                    m_owner = 2; m_pcpu = 0; m_last_ip = 0;
                    m_held = 0; m_gc = (m_gc < CMAX) ? m_gc + 1 : CMAX;
                end
            end else begin
                if (m_owner == 1) begin
                    m_pcpu |= cpu_req;
                    if (ip_rel) m_pip |= ip_req;
                end else begin
                    m_pip |= ip_req;
                    if (cpu_rel) m_pcpu |= cpu_req;
                end
                if ((m_owner == 1 && ip_rel) || (m_owner == 2 && cpu_rel)) begin
                    m_owner = 0; m_guard = G;
                end else if (m_expire) begin
                    m_owner = 0; m_guard = G; m_tp = 1;
                    m_rc = (m_rc < CMAX) ? m_rc + 1 : CMAX;
                end else begin
                    m_held++;
                end
            end
        end
    end

    always @(negedge clk_int) begin
        if (!rst_int) begin
            chk("ip_grant", ip_grant, m_owner == 1);
            chk("cpu_grant", cpu_grant, m_owner == 2);
            chk("app_data_grant", app_data_grant, {7'b0, m_owner == 1});
            chk("busy", busy, (m_owner != 0) || (m_guard > 0));
            chk("grant_count", grant_count, m_gc);
            chk("revoke_count", revoke_count, m_rc);
            chk("timeout_pulse", timeout_pulse, m_tp);
            chk("exclusive", ip_grant & cpu_grant, 0);
        end
    end

    task automatic cyc(input bit ir, input bit il,
                       input bit cr, input bit cl);
        ip_req = ir; ip_rel = il; cpu_req = cr; cpu_rel = cl;
        @(negedge clk_int); #1;
        ip_req = 0; ip_rel = 0; cpu_req = 0; cpu_rel = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst_int = 1;
        @(negedge clk_int); @(negedge clk_int); #1;
        rst_int = 0;
    endtask

    initial begin
        #1;
        do_reset();
        chk("rst_ip_grant", ip_grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gc", grant_count, 0);

        // 1: single IP grant, release, guard gap of two cycles
        idle(3);
        cyc(1, 0, 0, 0);
        chk("t1_grant", ip_grant, 1);
        chk("t1_adg", app_data_grant, 8'h01);
        chk("t1_model_gc", m_gc, 1);
        idle(9);
        cyc(0, 1, 0, 0);
        chk("t1_drop", ip_grant, 0);
        chk("t1_busy_guard", busy, 1);
        idle(1);
        chk("t1_busy_guard2", busy, 1);
        idle(1);
        chk("t1_busy_idle", busy, 0);
        chk("t1_gc", grant_count, 1);

        // 2: tie after reset goes to IP, CPU follows 3 cycles after drop
        do_reset();
        cyc(1, 0, 1, 0);
        chk("t2_ip_first", ip_grant, 1);
        chk("t2_cpu_wait", cpu_grant, 0);
        idle(2);
        cyc(0, 1, 0, 0);
        idle(2);
        chk("t2_cpu_not_yet", cpu_grant, 0);
        idle(1);
        chk("t2_cpu_grant", cpu_grant, 1);
        cyc(0, 0, 0, 1);
        idle(2);
        cyc(1, 0, 1, 0);
        chk("t2_tie_ip_after_cpu", ip_grant, 1);
        chk("t2_model_last", m_last_ip, 1);

        // 3: CPU releases while IP requests in the same cycle
        do_reset();
        cyc(0, 0, 1, 0);
        chk("t3_cpu_own", cpu_grant, 1);
        idle(2);
        cyc(1, 0, 0, 1);
        chk("t3_cpu_drop", cpu_grant, 0);
        idle(2);
        chk("t3_ip_wait", ip_grant, 0);
        idle(1);
        chk("t3_ip_grant", ip_grant, 1);

        // 4: stray releases and owner re-request change nothing
        do_reset();
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 1);
        chk("t4_idle_busy", busy, 0);
        chk("t4_idle_gc", grant_count, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 1);
        chk("t4_nonowner_rel", ip_grant, 1);
        cyc(1, 0, 0, 0);
        chk("t4_owner_req", ip_grant, 1);
        chk("t4_gc", grant_count, 1);
        cyc(0, 1, 0, 0);
        idle(3);
        chk("t4_no_regrant", busy, 0);

        // 5: hold-timeout watchdog
        do_reset();
        cyc(0, 0, 1, 0);
        chk("t5_rise", cpu_grant, 1);
`ifdef ARB_TIMEOUT_EN
        idle(TO - 1);
        chk("t5_held", cpu_grant, 1);
        idle(1);
        chk("t5_revoked", cpu_grant, 0);
        chk("t5_pulse", timeout_pulse, 1);
        chk("t5_rc", revoke_count, 1);
        idle(1);
        chk("t5_pulse_end", timeout_pulse, 0);
`else
        idle(1000);
        chk("t5_hold", cpu_grant, 1);
        chk("t5_rc", revoke_count, 0);
`endif

        // 6: reset mid-grant is immediate; grant_count saturates
        do_reset();
        cyc(1, 0, 0, 0);
        rst_int = 1;
        #1;
        chk("t6_async_drop", ip_grant, 0);
        chk("t6_async_gc", grant_count, 0);
        @(negedge clk_int); #1;
        rst_int = 0;
        for (int i = 0; i < CMAX + 2; i++) begin
            cyc(1, 0, 0, 0);
            cyc(0, 1, 0, 0);
            idle(2);
        end
        chk("t6_sat", grant_count, CMAX);

        // randomized traffic with rare resets
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
            end else begin
                cyc($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 12,
                    $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 12);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
